// File: rtl/proc_pkg.sv
// Shared processor definitions: bus widths, instruction field bounds and the
// fetch entry handed from the fetch unit to decode.
package proc_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 16;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int R1_MSB  = 26;
  localparam int R1_LSB  = 24;
  localparam int R2_MSB  = 23;
  localparam int R2_LSB  = 21;
  localparam int R3_MSB  = 20;
  localparam int R3_LSB  = 18;
  localparam int IMM_MSB = 20;
  localparam int IMM_LSB = 5;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Word-granular PC step; wraps from FFFF to 0000 silently.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with zero-latency head, synchronous flush and occupancy count.
module sync_fifo #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !flush && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential word fetch from a 1-cycle RAM into a
// prefetch FIFO, valid/ready delivery to decode, redirect flush.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  localparam int               CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_data,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_addr,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  input  logic               i_instr_ready,
  output logic [CNT_W-1:0]   o_fifo_count
);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc_p1;
  logic              inflight_p1;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    used;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // Credit counts the in-flight slot but not a same-cycle pop, so it never overflows.
  assign used       = {1'b0, count} + (CNT_W+1)'(inflight_p1);
  assign o_mem_req  = !i_reset && !i_redirect && (used < (CNT_W+1)'(DEPTH));
  assign o_mem_addr = pc;

  // Stage p0 -> p1: request issued, RAM returns data next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc          <= RESET_PC;
      inflight_p1 <= 1'b0;
    end else if (i_redirect) begin
      pc          <= i_redirect_addr;
      inflight_p1 <= 1'b0;
    end else begin
      inflight_p1 <= o_mem_req;
      if (o_mem_req) pc <= next_pc(pc);
    end
  end

  always_ff @(posedge i_clk) begin
    req_pc_p1 <= pc;
  end

  // Stage p1 -> FIFO: a response landing during a redirect belongs to the old stream.
  assign push             = inflight_p1 && !i_redirect;
  assign push_entry.instr = i_mem_data;
  assign push_entry.pc    = req_pc_p1;

  assign o_instr_valid = (count != '0) && !i_redirect;
  assign pop           = o_instr_valid && i_instr_ready;
  assign o_instr       = head_entry.instr;
  assign o_instr_pc    = head_entry.pc;
  assign o_fifo_count  = count;

  sync_fifo #(
    .DATA_W($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .flush    (i_redirect),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head_entry),
    .count    (count)
  );

  a_credit: assert property (@(posedge i_clk) disable iff (i_reset)
                             used <= (CNT_W+1)'(DEPTH));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected deliveries queued by the
// stimulus, compared by per-instance monitors on every accepted instruction.
module tb_instr_fetch_unit;
  import proc_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req, valid, ready, redir;
  logic [15:0] mem_addr, redir_addr, ipc;
  logic [31:0] mem_data, instr;
  logic [2:0]  cnt;

  logic        mem_req2, valid2, ready2, redir2;
  logic [15:0] mem_addr2, redir_addr2, ipc2;
  logic [31:0] mem_data2, instr2;
  logic [2:0]  cnt2;

  fetch_entry_t q1[$];
  fetch_entry_t q2[$];
  fetch_entry_t e1, e2;
  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_reset(rst), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_data(mem_data), .i_redirect(redir), .i_redirect_addr(redir_addr),
    .o_instr_valid(valid), .o_instr(instr), .o_instr_pc(ipc),
    .i_instr_ready(ready), .o_fifo_count(cnt)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
    .i_clk(clk), .i_reset(rst), .o_mem_req(mem_req2), .o_mem_addr(mem_addr2),
    .i_mem_data(mem_data2), .i_redirect(redir2), .i_redirect_addr(redir_addr2),
    .o_instr_valid(valid2), .o_instr(instr2), .o_instr_pc(ipc2),
    .i_instr_ready(ready2), .o_fifo_count(cnt2)
  );

  // RAM contents: word k holds A000_0000 + k, one cycle read latency
  always_ff @(posedge clk) begin
    mem_data  <= 32'hA000_0000 + {16'h0000, mem_addr};
    mem_data2 <= 32'hA000_0000 + {16'h0000, mem_addr2};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic fetch_entry_t ent(input logic [31:0] d, input logic [15:0] a);
    fetch_entry_t e;
    e.instr = d;
    e.pc    = a;
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid && ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut_unexpected: got pc=%h instr=%h expected nothing", ipc, instr);
      end else begin
        e1 = q1.pop_front();
        chk("dut_instr", instr, e1.instr);
        chk("dut_pc", {16'h0, ipc}, {16'h0, e1.pc});
      end
    end
    if (valid2 && ready2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_unexpected: got pc=%h instr=%h expected nothing", ipc2, instr2);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_instr", instr2, e2.instr);
        chk("dut2_pc", {16'h0, ipc2}, {16'h0, e2.pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input int which);
    int n = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL drain_timeout_%0d: left %0d entries, expected 0",
               which, (which == 1) ? q1.size() : q2.size());
      if (which == 1) q1.delete(); else q2.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; ready = 1'b0; redir = 1'b0; redir_addr = 16'h0;
    ready2 = 1'b0; redir2 = 1'b0; redir_addr2 = 16'h0;
    #2;
    chk("reset_req", 32'(mem_req), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_count", 32'(cnt), 32'd0);

    // Streaming from reset with decode always ready
    ready = 1'b1;
    for (int k = 0; k < 8; k++) q1.push_back(ent(32'hA000_0000 + k, 16'(k)));
    do_reset();
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h0000);
    chk("valid_c0", 32'(valid), 32'd0);
    tick();
    chk("valid_c1", 32'(valid), 32'd0);
    tick();
    chk("valid_c2", 32'(valid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("no_bubble", 32'(valid), 32'd1);
    end
    wait_drain(1);
    ready = 1'b0;

    // Backpressure: exactly DEPTH requests then stall
    do_reset();
    n = int'(mem_req);
    for (int i = 0; i < 9; i++) begin
      tick();
      n += int'(mem_req);
    end
    chk("stall_req_total", 32'(n), 32'd4);
    chk("stall_req", 32'(mem_req), 32'd0);
    chk("stall_count", 32'(cnt), 32'd4);
    chk("stall_pc", 32'(mem_addr), 32'h0004);
    for (int k = 0; k < 6; k++) q1.push_back(ent(32'hA000_0000 + k, 16'(k)));
    ready = 1'b1;
    wait_drain(1);
    ready = 1'b0;

    // Redirect with 3 buffered entries and one response in flight
    do_reset();
    repeat (4) tick();
    chk("pre_redir_count", 32'(cnt), 32'd3);
    chk("pre_redir_req", 32'(mem_req), 32'd0);
    redir = 1'b1; redir_addr = 16'h0100;
    #1;
    chk("redir_valid", 32'(valid), 32'd0);
    chk("redir_req", 32'(mem_req), 32'd0);
    tick();
    redir = 1'b0;
    #1;
    chk("post_redir_count", 32'(cnt), 32'd0);
    chk("post_redir_valid", 32'(valid), 32'd0);
    chk("post_redir_req", 32'(mem_req), 32'd1);
    chk("post_redir_addr", 32'(mem_addr), 32'h0100);
    q1.push_back(ent(32'hA000_0100, 16'h0100));
    q1.push_back(ent(32'hA000_0101, 16'h0101));
    q1.push_back(ent(32'hA000_0102, 16'h0102));
    ready = 1'b1;
    tick();
    chk("post_redir_valid2", 32'(valid), 32'd0);
    wait_drain(1);
    ready = 1'b0;

    // Redirect while decode is ready, then a second redirect overriding it
    repeat (6) tick();
    chk("full_count", 32'(cnt), 32'd4);
    ready = 1'b1; redir = 1'b1; redir_addr = 16'h0300;
    #1;
    chk("redir_pop_valid", 32'(valid), 32'd0);
    tick();
    redir_addr = 16'h0200;
    #1;
    chk("redir2_valid", 32'(valid), 32'd0);
    tick();
    redir = 1'b0;
    q1.push_back(ent(32'hA000_0200, 16'h0200));
    q1.push_back(ent(32'hA000_0201, 16'h0201));
    q1.push_back(ent(32'hA000_0202, 16'h0202));
    wait_drain(1);
    ready = 1'b0;

    // PC wrap with RESET_PC = FFFE
    q2.push_back(ent(32'hA000_FFFE, 16'hFFFE));
    q2.push_back(ent(32'hA000_FFFF, 16'hFFFF));
    q2.push_back(ent(32'hA000_0000, 16'h0000));
    q2.push_back(ent(32'hA000_0001, 16'h0001));
    ready2 = 1'b1;
    do_reset();
    wait_drain(2);
    ready2 = 1'b0;

    // Asynchronous reset with a full FIFO of a distinct stream
    redir = 1'b1; redir_addr = 16'h0500;
    tick();
    redir = 1'b0;
    repeat (8) tick();
    chk("prerst_count", 32'(cnt), 32'd4);
    chk("prerst_valid", 32'(valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_count", 32'(cnt), 32'd0);
    chk("async_rst_req", 32'(mem_req), 32'd0);
    tick();
    rst = 1'b0;
    q1.push_back(ent(32'hA000_0000, 16'h0000));
    q1.push_back(ent(32'hA000_0001, 16'h0001));
    q1.push_back(ent(32'hA000_0002, 16'h0002));
    ready = 1'b1;
    wait_drain(1);
    ready = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
